// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer:
// FSM state encodings, the bubble instruction word and a sizing helper.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_STALL = 2'd1,
        ST_FLUSH = 2'd2,
        ST_WAIT  = 2'd3
    } state_e;

    localparam logic [31:0] NOP_IR = 32'h0000_0013;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_cmp.sv
// RAW hazard detection between the ID instruction's sources and the EX/MEM
// destination registers. x0 never creates a hazard.
module hazard_cmp (
    input  logic [4:0] rs1_i,
    input  logic [4:0] rs2_i,
    input  logic       use_rs1_i,
    input  logic       use_rs2_i,
    input  logic [4:0] ex_rd_i,
    input  logic       ex_we_i,
    input  logic [4:0] mem_rd_i,
    input  logic       mem_we_i,
    output logic       hz_ex_o,
    output logic       hz_mem_o
);

    function automatic logic raw_match(input logic we, input logic [4:0] rd,
                                       input logic u1, input logic [4:0] r1,
                                       input logic u2, input logic [4:0] r2);
        return we && (rd != 5'd0) && ((u1 && (r1 == rd)) || (u2 && (r2 == rd)));
    endfunction

    assign hz_ex_o  = raw_match(ex_we_i,  ex_rd_i,  use_rs1_i, rs1_i, use_rs2_i, rs2_i);
    assign hz_mem_o = raw_match(mem_we_i, mem_rd_i, use_rs1_i, rs1_i, use_rs2_i, rs2_i);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: data-hazard bubbles, redirect
// flushes and whole-pipe freeze on outstanding data-memory accesses.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int EX_BUBBLES   = 2,
    parameter int MEM_BUBBLES  = 1,
    parameter int FLUSH_CYCLES = 1,
    parameter int PERF_W       = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [4:0]        ID_rs1,
    input  logic [4:0]        ID_rs2,
    input  logic              ID_use_rs1,
    input  logic              ID_use_rs2,
    input  logic [4:0]        EX_rd,
    input  logic              EX_RegWrite,
    input  logic [4:0]        MEM_rd,
    input  logic              MEM_RegWrite,
    input  logic              EX_redirect,
    input  logic              MEM_req,
    input  logic              mem_ack,
    output logic              PC_EN,
    output logic              IFID_EN,
    output logic              IFID_flush,
    output logic              IDEX_EN,
    output logic              IDEX_flush,
    output logic              EXMEM_EN,
    output logic              MEMWB_EN,
    output logic [1:0]        busy_state,
    output logic [PERF_W-1:0] stall_cycles
);

    localparam int CW = $clog2(max3(EX_BUBBLES, MEM_BUBBLES, FLUSH_CYCLES) + 1);
    typedef logic [CW-1:0] cnt_t;

    localparam cnt_t EX_LOAD  = cnt_t'(EX_BUBBLES - 1);
    localparam cnt_t MEM_LOAD = cnt_t'(MEM_BUBBLES - 1);
    localparam cnt_t FL_LOAD  = cnt_t'(FLUSH_CYCLES - 1);

    if (EX_BUBBLES < 1 || MEM_BUBBLES < 1 || FLUSH_CYCLES < 1 || PERF_W < 1) begin : g_param_check
        $error("pipeline_hazard_ctrl: all parameters must be >= 1");
    end

    state_e            state_q, state_d;
    state_e            saved_q, saved_d;
    state_e            resume;
    cnt_t              cnt_q, cnt_d;
    logic              live_q;
    logic [PERF_W-1:0] stall_q;
    logic              hz_ex, hz_mem;

    hazard_cmp u_cmp (
        .rs1_i     (ID_rs1),
        .rs2_i     (ID_rs2),
        .use_rs1_i (ID_use_rs1),
        .use_rs2_i (ID_use_rs2),
        .ex_rd_i   (EX_rd),
        .ex_we_i   (EX_RegWrite),
        .mem_rd_i  (MEM_rd),
        .mem_we_i  (MEM_RegWrite),
        .hz_ex_o   (hz_ex),
        .hz_mem_o  (hz_mem)
    );

    // Outputs are Mealy: the reaction happens in the cycle the condition is seen.
    always_comb begin
        resume     = (state_q == ST_WAIT) ? saved_q : state_q;
        state_d    = resume;
        saved_d    = saved_q;
        cnt_d      = cnt_q;
        PC_EN      = 1'b1;
        IFID_EN    = 1'b1;
        IFID_flush = 1'b0;
        IDEX_EN    = 1'b1;
        IDEX_flush = 1'b0;
        EXMEM_EN   = 1'b1;
        MEMWB_EN   = 1'b1;

        if (MEM_req && !mem_ack) begin
            PC_EN    = 1'b0;
            IFID_EN  = 1'b0;
            IDEX_EN  = 1'b0;
            EXMEM_EN = 1'b0;
            MEMWB_EN = 1'b0;
            state_d  = ST_WAIT;
            saved_d  = resume;
        end else if (EX_redirect) begin
            IFID_flush = 1'b1;
            IDEX_flush = 1'b1;
            cnt_d      = FL_LOAD;
            state_d    = (FLUSH_CYCLES > 1) ? ST_FLUSH : ST_RUN;
        end else begin
            case (resume)
                ST_FLUSH: begin
                    IFID_flush = 1'b1;
                    IDEX_flush = 1'b1;
                    cnt_d      = cnt_q - cnt_t'(1);
                    state_d    = (cnt_q <= cnt_t'(1)) ? ST_RUN : ST_FLUSH;
                end
                ST_STALL: begin
                    PC_EN      = 1'b0;
                    IFID_EN    = 1'b0;
                    IDEX_flush = 1'b1;
                    cnt_d      = cnt_q - cnt_t'(1);
                    state_d    = (cnt_q <= cnt_t'(1)) ? ST_RUN : ST_STALL;
                end
                default: begin
                    if (hz_ex || hz_mem) begin
                        PC_EN      = 1'b0;
                        IFID_EN    = 1'b0;
                        IDEX_flush = 1'b1;
                        cnt_d      = hz_ex ? EX_LOAD : MEM_LOAD;
                        state_d    = (cnt_d != cnt_t'(0)) ? ST_STALL : ST_RUN;
                    end
                end
            endcase
        end

        // Pipe stays frozen until the first clock edge after reset release.
        if (!live_q) begin
            PC_EN      = 1'b0;
            IFID_EN    = 1'b0;
            IFID_flush = 1'b1;
            IDEX_EN    = 1'b0;
            IDEX_flush = 1'b1;
            EXMEM_EN   = 1'b0;
            MEMWB_EN   = 1'b0;
            state_d    = state_q;
            saved_d    = saved_q;
            cnt_d      = cnt_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_RUN;
            saved_q <= ST_RUN;
            cnt_q   <= '0;
            live_q  <= 1'b0;
            stall_q <= '0;
        end else begin
            live_q  <= 1'b1;
            state_q <= state_d;
            saved_q <= saved_d;
            cnt_q   <= cnt_d;
            if (live_q && !PC_EN) begin
                stall_q <= stall_q + PERF_W'(1);
            end
        end
    end

    assign busy_state   = state_q;
    assign stall_cycles = stall_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Randomized and directed checks of the hazard sequencer against a counter-based
// reference model; two instances with different parameter sets share stimulus.
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [4:0] ID_rs1 = '0, ID_rs2 = '0, EX_rd = '0, MEM_rd = '0;
    logic       ID_use_rs1 = 0, ID_use_rs2 = 0, EX_RegWrite = 0, MEM_RegWrite = 0;
    logic       EX_redirect = 0, MEM_req = 0, mem_ack = 0;

    logic        pc0, ifen0, iffl0, iden0, idfl0, exen0, mwen0;
    logic        pc1, ifen1, iffl1, iden1, idfl1, exen1, mwen1;
    logic [1:0]  bs0, bs1;
    logic [31:0] sc0;
    logic [3:0]  sc1;

    always #5 clk = ~clk;

    pipeline_hazard_ctrl u_dut0 (
        .clk(clk), .rst(rst),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
        .EX_rd(EX_rd), .EX_RegWrite(EX_RegWrite), .MEM_rd(MEM_rd), .MEM_RegWrite(MEM_RegWrite),
        .EX_redirect(EX_redirect), .MEM_req(MEM_req), .mem_ack(mem_ack),
        .PC_EN(pc0), .IFID_EN(ifen0), .IFID_flush(iffl0), .IDEX_EN(iden0), .IDEX_flush(idfl0),
        .EXMEM_EN(exen0), .MEMWB_EN(mwen0), .busy_state(bs0), .stall_cycles(sc0)
    );

    pipeline_hazard_ctrl #(.EX_BUBBLES(3), .MEM_BUBBLES(2), .FLUSH_CYCLES(2), .PERF_W(4)) u_dut1 (
        .clk(clk), .rst(rst),
        .ID_rs1(ID_rs1), .ID_rs2(ID_rs2), .ID_use_rs1(ID_use_rs1), .ID_use_rs2(ID_use_rs2),
        .EX_rd(EX_rd), .EX_RegWrite(EX_RegWrite), .MEM_rd(MEM_rd), .MEM_RegWrite(MEM_RegWrite),
        .EX_redirect(EX_redirect), .MEM_req(MEM_req), .mem_ack(mem_ack),
        .PC_EN(pc1), .IFID_EN(ifen1), .IFID_flush(iffl1), .IDEX_EN(iden1), .IDEX_flush(idfl1),
        .EXMEM_EN(exen1), .MEMWB_EN(mwen1), .busy_state(bs1), .stall_cycles(sc1)
    );

    // Output vectors: {PC_EN, IFID_EN, IFID_flush, IDEX_EN, IDEX_flush, EXMEM_EN, MEMWB_EN}
    localparam logic [6:0] O_RUN   = 7'b1101011;
    localparam logic [6:0] O_STALL = 7'b0001111;
    localparam logic [6:0] O_FLUSH = 7'b1111111;
    localparam logic [6:0] O_WAIT  = 7'b0000000;
    localparam logic [6:0] O_RESET = 7'b0010100;

    int exb [2] = '{2, 3};
    int memb[2] = '{1, 2};
    int flc [2] = '{1, 2};
    int pw  [2] = '{32, 4};

    // Reference model: remaining stall bubbles, remaining flush cycles, waiting flag, perf count.
    int          sl[2], fl[2];
    bit          wt[2];
    logic [31:0] perf[2];

    int checks = 0;
    int failures = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: observed=%0h expected=%0h at t=%0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [6:0] outs(input int i);
        return (i == 0) ? {pc0, ifen0, iffl0, iden0, idfl0, exen0, mwen0}
                        : {pc1, ifen1, iffl1, iden1, idfl1, exen1, mwen1};
    endfunction

    function automatic logic [31:0] mask(input int i);
        return (pw[i] >= 32) ? 32'hFFFF_FFFF : ((32'd1 << pw[i]) - 32'd1);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 2; i++) begin
            sl[i] = 0; fl[i] = 0; wt[i] = 0; perf[i] = 0;
        end
    endtask

    task automatic set_idle();
        ID_rs1 = 0; ID_rs2 = 0; ID_use_rs1 = 0; ID_use_rs2 = 0;
        EX_rd = 0; EX_RegWrite = 0; MEM_rd = 0; MEM_RegWrite = 0;
        EX_redirect = 0; MEM_req = 0; mem_ack = 0;
    endtask

    // Checks one cycle with the inputs currently applied, then advances the model.
    task automatic step(input string tag);
        int         nsl[2], nfl[2];
        bit         nwt[2];
        logic [6:0] e;
        bit         hzx, hzm, w;
        @(negedge clk);
        hzx = EX_RegWrite && EX_rd != 0 &&
              ((ID_use_rs1 && ID_rs1 == EX_rd) || (ID_use_rs2 && ID_rs2 == EX_rd));
        hzm = MEM_RegWrite && MEM_rd != 0 &&
              ((ID_use_rs1 && ID_rs1 == MEM_rd) || (ID_use_rs2 && ID_rs2 == MEM_rd));
        w = MEM_req && !mem_ack;
        for (int i = 0; i < 2; i++) begin
            int st;
            st = wt[i] ? 3 : (fl[i] > 0) ? 2 : (sl[i] > 0) ? 1 : 0;
            check({tag, "_state"}, (i == 0) ? bs0 : bs1, st);
            check({tag, "_perf"}, (i == 0) ? sc0 : {28'd0, sc1}, perf[i]);
            nsl[i] = sl[i]; nfl[i] = fl[i]; nwt[i] = w;
            if (w) begin
                e = O_WAIT;
            end else if (EX_redirect) begin
                e = O_FLUSH; nsl[i] = 0; nfl[i] = flc[i] - 1;
            end else if (fl[i] > 0) begin
                e = O_FLUSH; nfl[i] = fl[i] - 1;
            end else if (sl[i] > 0) begin
                e = O_STALL; nsl[i] = sl[i] - 1;
            end else if (hzx) begin
                e = O_STALL; nsl[i] = exb[i] - 1;
            end else if (hzm) begin
                e = O_STALL; nsl[i] = memb[i] - 1;
            end else begin
                e = O_RUN;
            end
            check({tag, "_outs"}, outs(i), e);
            if (!e[6]) perf[i] = (perf[i] + 1) & mask(i);
        end
        @(posedge clk);
        for (int i = 0; i < 2; i++) begin
            sl[i] = nsl[i]; fl[i] = nfl[i]; wt[i] = nwt[i];
        end
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b0;
        set_idle();
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check("gap_outs0", outs(0), O_RESET);
        check("gap_outs1", outs(1), O_RESET);
        @(posedge clk); #1;
        model_reset();
    endtask

    task automatic ex_hazard();
        ID_rs1 = 5; ID_use_rs1 = 1; EX_rd = 5; EX_RegWrite = 1;
    endtask

    logic [31:0] base;

    initial begin
        set_idle();
        model_reset();
        #2;
        @(negedge clk);
        check("rst_outs0", outs(0), O_RESET);
        check("rst_outs1", outs(1), O_RESET);
        check("rst_perf0", sc0, 0);
        do_reset();

        base = sc0;
        ex_hazard(); step("exhz0");
        set_idle();  repeat (3) step("exhz");
        check("exhz_perf_delta", sc0 - base, 2);

        ID_rs2 = 7; ID_use_rs2 = 1; MEM_rd = 7; MEM_RegWrite = 1; step("memhz0");
        set_idle(); repeat (3) step("memhz");

        EX_rd = 0; EX_RegWrite = 1; ID_rs1 = 0; ID_use_rs1 = 1; step("x0");
        check("x0_pc_en", pc0, 1);
        set_idle(); step("x0b");

        ex_hazard(); step("redir0");
        set_idle(); EX_redirect = 1; step("redir1");
        EX_redirect = 0; repeat (3) step("redir2");

        base = sc0;
        ex_hazard(); step("wait0");
        set_idle(); MEM_req = 1; mem_ack = 0; repeat (3) step("wait");
        mem_ack = 1; step("wait_ack");
        set_idle(); repeat (3) step("wait_done");
        check("wait_perf_delta", sc0 - base, 5);

        ex_hazard(); step("arst0");
        set_idle(); #2 rst = 1'b0; #1;
        check("arst_outs0", outs(0), O_RESET);
        check("arst_state0", bs0, 0);
        check("arst_perf0", sc0, 0);
        #2 rst = 1'b1;
        @(posedge clk); #1;
        model_reset();
        step("arst_run");

        for (int n = 0; n < 600; n++) begin
            ID_rs1       = 5'($urandom_range(0, 3));
            ID_rs2       = 5'($urandom_range(0, 3));
            ID_use_rs1   = 1'($urandom_range(0, 1));
            ID_use_rs2   = 1'($urandom_range(0, 1));
            EX_rd        = 5'($urandom_range(0, 3));
            EX_RegWrite  = 1'($urandom_range(0, 1));
            MEM_rd       = 5'($urandom_range(0, 3));
            MEM_RegWrite = 1'($urandom_range(0, 1));
            EX_redirect  = ($urandom_range(0, 9) == 0);
            MEM_req      = ($urandom_range(0, 4) == 0);
            mem_ack      = 1'($urandom_range(0, 1));
            step("rnd");
        end

        do_reset();
        MEM_req = 1; mem_ack = 0;
        repeat (17) step("wrap");
        set_idle();
        @(negedge clk);
        check("wrap_perf1", {28'd0, sc1}, 1);
        check("wrap_perf0", sc0, 17);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
